// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic {IDLE, REFILL} icache_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    localparam int DEF_LINES  = 16;
    localparam int DEF_WORDS  = 4;
    localparam int DEF_WORD_W = $clog2(DEF_WORDS);
    localparam int DEF_IDX_W  = $clog2(DEF_LINES);
    localparam int DEF_TAG_W  = 30 - DEF_WORD_W - DEF_IDX_W;

    // Tag is whatever remains of the word address above the index field.
    function automatic int tag_width(input int lines, input int words);
        return 30 - $clog2(lines) - $clog2(words);
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Flop-based valid/tag/data arrays: combinational read, one word-write port plus install strobe.
// Write of word 0 invalidates the line so a partial refill can never look like a hit.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int LINES  = DEF_LINES,
    parameter int WORDS  = DEF_WORDS,
    parameter int IDX_W  = $clog2(LINES),
    parameter int WORD_W = $clog2(WORDS),
    parameter int TAG_W  = tag_width(LINES, WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [WORD_W-1:0] rd_word,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [31:0]       rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [31:0]       wr_data,
    input  logic              install,
    input  logic [TAG_W-1:0]  install_tag
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    logic [31:0]      data [LINES][WORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else begin
            if (wr_en && wr_word == '0)
                valid[wr_idx] <= 1'b0;
            if (install)
                valid[wr_idx] <= 1'b1;
        end
    end

    // Tags and data are deliberately not reset; valid gates every use.
    always_ff @(posedge clk) begin
        if (wr_en)
            data[wr_idx][wr_word] <= wr_data;
        if (install)
            tags[wr_idx] <= install_tag;
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx][rd_word];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped I-cache: hits return InstrF combinationally; misses stall and refill a line word 0..WORDS-1.
// Refill waits on MemAckF per word; define ICACHE_PERF_EN to add HitCountF/MissCountF.
module icache_dm
    import icache_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int WORDS = DEF_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    output logic [31:0] InstrF,
    output logic        StallICacheF,
    output logic        MemReqF,
    output logic [31:0] MemAddrF,
    input  logic [31:0] MemRDataF,
    input  logic        MemAckF
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] HitCountF,
    output logic [31:0] MissCountF
`endif
);

    localparam int WORD_W = $clog2(WORDS);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = tag_width(LINES, WORDS);

    icache_state_t state, next_state;

    logic [WORD_W-1:0] pc_word;
    logic [IDX_W-1:0]  pc_idx;
    logic [TAG_W-1:0]  pc_tag;
    logic              unused_pc_lsb;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [31:0]       rd_data;

    logic [IDX_W-1:0]  lat_idx;
    logic [TAG_W-1:0]  lat_tag;
    logic [WORD_W-1:0] cnt;
    logic              last_word;
    logic              hit;
    logic              wr_en;
    logic              install;

    assign pc_word       = PCF[2 +: WORD_W];
    assign pc_idx        = PCF[2 + WORD_W +: IDX_W];
    assign pc_tag        = PCF[31 -: TAG_W];
    assign unused_pc_lsb = ^PCF[1:0];
    assign last_word     = (cnt == WORD_W'(WORDS - 1));

    icache_line_store #(
        .LINES  (LINES),
        .WORDS  (WORDS),
        .IDX_W  (IDX_W),
        .WORD_W (WORD_W),
        .TAG_W  (TAG_W)
    ) u_store (
        .clk         (clk),
        .reset       (reset),
        .rd_idx      (pc_idx),
        .rd_word     (pc_word),
        .rd_valid    (rd_valid),
        .rd_tag      (rd_tag),
        .rd_data     (rd_data),
        .wr_en       (wr_en),
        .wr_idx      (lat_idx),
        .wr_word     (cnt),
        .wr_data     (MemRDataF),
        .install     (install),
        .install_tag (lat_tag)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!hit) next_state = REFILL;
            REFILL:  if (install) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        hit          = rd_valid && (rd_tag == pc_tag) && (state == IDLE);
        StallICacheF = !hit;
        InstrF       = hit ? rd_data : NOP_INSTR;
        wr_en        = (state == REFILL) && MemReqF && MemAckF;
        install      = wr_en && last_word;
    end

    // Index and tag are captured at the miss so a misbehaving PCF cannot redirect the refill.
    always_ff @(posedge clk) begin
        if (reset) begin
            MemReqF  <= 1'b0;
            MemAddrF <= '0;
            cnt      <= '0;
            lat_idx  <= '0;
            lat_tag  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!hit) begin
                        lat_idx  <= pc_idx;
                        lat_tag  <= pc_tag;
                        cnt      <= '0;
                        MemReqF  <= 1'b1;
                        MemAddrF <= {PCF[31:2+WORD_W], {(WORD_W+2){1'b0}}};
                    end
                end
                REFILL: begin
                    if (wr_en) begin
                        if (last_word) begin
                            MemReqF <= 1'b0;
                        end else begin
                            cnt      <= cnt + 1'b1;
                            MemAddrF <= MemAddrF + 32'd4;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            HitCountF  <= '0;
            MissCountF <= '0;
        end else begin
            if (hit)
                HitCountF <= HitCountF + 32'd1;
            if (state == IDLE && !hit)
                MissCountF <= MissCountF + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm with a behavioural memory of configurable per-word ack latency.
module tb_icache_dm;

    localparam int          WORDS = 4;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCF;
    logic [31:0] InstrF;
    logic        StallICacheF;
    logic        MemReqF;
    logic [31:0] MemAddrF;
    logic [31:0] MemRDataF;
    logic        MemAckF;
`ifdef ICACHE_PERF_EN
    logic [31:0] HitCountF;
    logic [31:0] MissCountF;
`endif

    always #5 clk = ~clk;

    icache_dm dut (
        .clk          (clk),
        .reset        (reset),
        .PCF          (PCF),
        .InstrF       (InstrF),
        .StallICacheF (StallICacheF),
        .MemReqF      (MemReqF),
        .MemAddrF     (MemAddrF),
        .MemRDataF    (MemRDataF),
        .MemAckF      (MemAckF)
`ifdef ICACHE_PERF_EN
        ,
        .HitCountF    (HitCountF),
        .MissCountF   (MissCountF)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          lat = 1;
    int          wcnt = 0;
    int          acks = 0;
    int          req_cycles = 0;
    int          addr_moves = 0;
    int          tb_hits = 0;
    bit          spurious = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] ack_addr [$];

    // Memory model: data word equals its byte address; ack after lat request cycles.
    always @(negedge clk) begin
        if (reset) tb_hits = 0;
        else if (!StallICacheF) tb_hits++;
        if (MemReqF) begin
            req_cycles++;
            if (wcnt > 0 && MemAddrF !== prev_addr) addr_moves++;
            prev_addr = MemAddrF;
            if (wcnt == lat - 1) begin
                MemAckF   = 1'b1;
                MemRDataF = MemAddrF;
                ack_addr.push_back(MemAddrF);
                acks++;
                wcnt = 0;
            end else begin
                MemAckF = 1'b0;
                wcnt++;
            end
        end else begin
            MemAckF   = spurious;
            MemRDataF = 32'hBAD0_BAD0;
            wcnt      = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic stall_len(output int n);
        n = 0;
        while (StallICacheF && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic fill(input logic [31:0] pc, input int exp_n, input string tag);
        int n;
        ack_addr.delete();
        PCF = pc;
        #1;
        stall_len(n);
        chk({tag, "_stall"}, 32'(n), 32'(exp_n));
        chk({tag, "_instr"}, InstrF, pc);
        chk({tag, "_nreq"}, 32'(ack_addr.size()), 32'(WORDS));
        foreach (ack_addr[i])
            chk({tag, "_addr"}, ack_addr[i], (pc & ~32'hF) + 32'(4 * i));
    endtask

    initial begin
        int n;
        int rq;
        int a0;
        logic [31:0] hit_pcs [3];
        reset     = 1'b1;
        PCF       = '0;
        MemAckF   = 1'b0;
        MemRDataF = '0;
        repeat (3) step();
        reset = 1'b0;
        #1;
        chk("rst_stall", 32'(StallICacheF), 32'd1);
        chk("rst_instr", InstrF, NOP);
        chk("rst_req", 32'(MemReqF), 32'd0);
        chk("rst_addr", MemAddrF, 32'd0);

        fill(32'h0, 5, "cold");

        hit_pcs = '{32'h4, 32'h8, 32'hC};
        rq = req_cycles;
        spurious = 1'b1;
        foreach (hit_pcs[i]) begin
            PCF = hit_pcs[i];
            #1;
            chk("hit_instr", InstrF, hit_pcs[i]);
            chk("hit_stall", 32'(StallICacheF), 32'd0);
            step();
        end
        spurious = 1'b0;
        chk("hit_noreq", 32'(req_cycles - rq), 32'd0);

        fill(32'h100, 5, "conf_a");
        fill(32'h0, 5, "conf_b");

        lat = 3;
        addr_moves = 0;
        fill(32'h80, 13, "slow");
        chk("slow_addr_hold", 32'(addr_moves), 32'd0);
        lat = 1;

        a0 = acks;
        PCF = 32'h40;
        n = 0;
        while (acks - a0 < 2 && n < 50) begin
            step();
            n++;
        end
        chk("abort_acks", 32'(acks - a0), 32'd2);
        reset = 1'b1;
        step();
        chk("abort_req", 32'(MemReqF), 32'd0);
        reset = 1'b0;
        fill(32'h0, 5, "post_rst");
        fill(32'h40, 5, "post_rst40");

`ifdef ICACHE_PERF_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        fill(32'h0, 5, "perf_m0");
        PCF = 32'h4;
        step();
        PCF = 32'h8;
        step();
        fill(32'h100, 5, "perf_m1");
        chk("perf_miss", MissCountF, 32'd2);
        chk("perf_hit_obs", HitCountF, 32'(tb_hits));
        chk("perf_hit", HitCountF, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
